effect_gate_env: RTL and testbench
==================================

Name: effect_gate_env

Overview:
Parametrised successor to the team's hard noise gate. It gates a signed PCM stream using open/close thresholds with hysteresis, a hold timer, and linear attack/release gain ramps, so the gate no longer switches hard. It sits in the effects chain between sample-valid stages, with one sample in and one sample out per i_valid strobe. A bypass input passes audio unchanged.

Parameters:
DATA_W, 16, sample width (signed two's complement)
LVL_W, 3, width of i_level
THR_STEP, 25, open threshold per level step (open_thr = i_level*THR_STEP)
HYST, 10, close_thr = open_thr - HYST, saturating at 0
GAIN_W, 8, gain fraction bits; GAIN_FULL = 2**GAIN_W (unity)
ATK_STEP, 64, gain increment per valid sample in ATTACK
REL_STEP, 32, gain decrement per valid sample in RELEASE
HOLD_SAMPLES, 4, valid samples held at full gain after the level drops (minimum 1)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_valid  in  1  input sample strobe
i_enable  in  1  1 = gate active, 0 = bypass
i_level  in  LVL_W  threshold select
i_data  in  DATA_W  signed input sample
o_data  out  DATA_W  signed gated sample, registered
o_valid  out  1  i_valid delayed by exactly 1 cycle

Behaviour:
- Clocking and reset: one clock, i_clk. i_rst is asynchronous and active-high. On reset: o_data=0, o_valid=0, state=CLOSED, gain=0, hold_cnt=0.
- Latency: 1 cycle. Every cycle, o_valid <= i_valid. o_data updates only on cycles with i_valid and holds its value otherwise.
- Absolute value: abs = |i_data|. The most-negative input saturates to 2**(DATA_W-1)-1.
- Threshold updates: open_thr and close_thr are recomputed from i_level each sample. A level change never resets the FSM.
- Level 0: open_thr=0, so the gate is always open or opening.
- State advance: the FSM advances only on i_valid with i_enable=1. All comparisons use the current sample.
- CLOSED: gain_next=0. If abs >= open_thr, go to ATTACK with gain_next=ATK_STEP.
- ATTACK: gain_next = min(gain+ATK_STEP, GAIN_FULL). On reaching GAIN_FULL, go to OPEN. If abs < close_thr, go to RELEASE with gain_next = gain-REL_STEP, floored at 0.
- OPEN: gain_next=GAIN_FULL. If abs < close_thr, go to HOLD and load hold_cnt = HOLD_SAMPLES-1.
- HOLD: gain_next=GAIN_FULL.
  - If abs >= open_thr, go to OPEN.
  - Otherwise, if hold_cnt==0, go to RELEASE with gain_next = GAIN_FULL-REL_STEP.
  - Otherwise, hold_cnt decrements.
- RELEASE: gain_next = max(gain-REL_STEP, 0). At 0, go to CLOSED. If abs >= open_thr, go to ATTACK with gain_next = min(gain+ATK_STEP, GAIN_FULL), and go directly to OPEN if that saturates.
- Hysteresis band (close_thr <= abs < open_thr): no transition from OPEN, CLOSED or HOLD. HOLD still counts down.
- Output arithmetic: o_data = (i_data * gain_next) >>> GAIN_W, with gain_next zero-extended to GAIN_W+1 bits, full-precision product, and an arithmetic shift (floor).
  - gain_next == GAIN_FULL gives o_data exactly equal to i_data.
  - The gain register takes gain_next.
- Bypass (i_enable=0): on i_valid, o_data = i_data. The FSM is forced to OPEN, gain=GAIN_FULL, hold_cnt=0, so re-enabling starts open.
- Reset mid-ramp: reset aborts immediately to the reset values.

Optional Feature:
EFFECT_GATE_METER_EN:
- Defined: adds outputs o_state (3 bits, encoding CLOSED=0, ATTACK=1, OPEN=2, HOLD=3, RELEASE=4) and o_gain (GAIN_W+1 bits). Both are registered copies of state and gain and are reset to 0 (CLOSED).
- Undefined: these ports and the registers behind them do not exist. Audio behaviour is identical either way.

Decomposition:
- Package gate_pkg holds:
  - the gate_state_e enum (CLOSED, ATTACK, OPEN, HOLD, RELEASE, encoded as above);
  - the abs_sat function;
  - the sat_add and sat_sub helpers for gain.
- One sub-module, gate_gain_apply: a combinational signed×unsigned multiply and shift, parametrised by DATA_W and GAIN_W, instanced once.

Test Plan (defaults, i_enable=1, i_level=4 → open=100, close=90):
1. Reset: assert i_rst mid-stream → o_data=0 and o_valid=0 within the same cycle, asynchronously. With the meter enabled, o_state=CLOSED.
2. Attack ramp:
   - Input 50 → output 0.
   - Then four samples of 200 → outputs 50, 100, 150, 200; state becomes OPEN.
3. Hysteresis, hold and release: from OPEN, input 95 → output 95 and state stays OPEN. Then six samples of 80 → outputs 80, 80, 80, 80, 70, 60.
4. Retrigger during release: with gain=192 in RELEASE, input 300 → output 300; state goes to OPEN and gain to 256.
5. Saturation: with i_level=7 (open=175) from CLOSED, input -32768 → abs 32767 opens the gate; output -8192.
6. Bypass and latency:
   - With i_enable=0, inputs 5, -3 and 0 pass unchanged with o_valid exactly 1 cycle after i_valid.
   - o_data holds between strobes.
   - Re-enabling with input 95 (hysteresis band) → output 95, since the gate resumes OPEN.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared types and arithmetic helpers for the effect_gate_env soft noise gate.
package gate_pkg;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } gate_state_e;

  // Magnitude of a sign-extended sample of width w; the most-negative code clamps to max positive.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int unsigned w);
    logic signed [31:0] min_v;
    min_v = -(32'sd1 <<< (w - 1));
    if (x == min_v)
      return (32'd1 << (w - 1)) - 32'd1;
    else if (x < 0)
      return $unsigned(-x);
    else
      return $unsigned(x);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [31:0] s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/gate_gain_apply.sv
// Combinational signed sample times unsigned Q(GAIN_W) gain, floor-shifted back to sample width.
module gate_gain_apply #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 8
) (
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic        [GAIN_W:0]   i_gain,
  output logic signed [DATA_W-1:0] o_sample
);
  localparam int PROD_W = DATA_W + GAIN_W + 2;

  logic signed [GAIN_W+1:0] w_gain_s;
  logic signed [PROD_W-1:0] w_prod;

  assign w_gain_s = $signed({1'b0, i_gain});
  assign w_prod   = PROD_W'(i_sample) * PROD_W'(w_gain_s);
  // Gain never exceeds unity, so the shifted product always fits the sample width.
  assign o_sample = DATA_W'(w_prod >>> GAIN_W);

endmodule

// File: rtl/effect_gate_env.sv
// Soft noise gate: hysteresis thresholds, hold timer and linear attack/release gain ramps.
// Define EFFECT_GATE_METER_EN to expose registered o_state / o_gain meter outputs.
module effect_gate_env
  import gate_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int LVL_W        = 3,
  parameter int THR_STEP     = 25,
  parameter int HYST         = 10,
  parameter int GAIN_W       = 8,
  parameter int ATK_STEP     = 64,
  parameter int REL_STEP     = 32,
  parameter int HOLD_SAMPLES = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic                     i_enable,
  input  logic        [LVL_W-1:0]  i_level,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid
`ifdef EFFECT_GATE_METER_EN
  ,
  output logic        [2:0]        o_state,
  output logic        [GAIN_W:0]   o_gain
`endif
);

  localparam int          HOLD_W    = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [31:0] GAIN_FULL = 32'd1 << GAIN_W;
  localparam logic [31:0] ATK_W     = 32'(ATK_STEP);
  localparam logic [31:0] REL_W     = 32'(REL_STEP);
  localparam logic [31:0] HYST_W    = 32'(HYST);

  gate_state_e              r_state;
  logic        [GAIN_W:0]   r_gain;
  logic        [HOLD_W-1:0] r_hold;
  logic signed [DATA_W-1:0] r_data;
  logic                     r_valid;

  gate_state_e              w_state_next;
  logic        [31:0]       w_gain_next;
  logic        [HOLD_W-1:0] w_hold_next;
  logic        [31:0]       w_abs;
  logic        [31:0]       w_open_thr;
  logic        [31:0]       w_close_thr;
  logic        [31:0]       w_ramp_up;
  logic        [31:0]       w_ramp_dn;
  logic signed [DATA_W-1:0] w_scaled;

  assign w_abs       = abs_sat({{(32-DATA_W){i_data[DATA_W-1]}}, i_data}, DATA_W);
  assign w_open_thr  = 32'(i_level) * 32'(THR_STEP);
  assign w_close_thr = sat_sub(w_open_thr, HYST_W);
  assign w_ramp_up   = sat_add(32'(r_gain), ATK_W, GAIN_FULL);
  assign w_ramp_dn   = sat_sub(32'(r_gain), REL_W);

  always_comb begin
    w_state_next = r_state;
    w_gain_next  = 32'(r_gain);
    w_hold_next  = r_hold;
    if (!i_enable) begin
      // Bypass parks the gate fully open so re-enabling never ramps from silence.
      w_state_next = OPEN;
      w_gain_next  = GAIN_FULL;
      w_hold_next  = '0;
    end else begin
      unique case (r_state)
        CLOSED: begin
          w_gain_next = 32'd0;
          if (w_abs >= w_open_thr) begin
            w_state_next = ATTACK;
            w_gain_next  = sat_add(32'd0, ATK_W, GAIN_FULL);
          end
        end
        ATTACK: begin
          if (w_abs < w_close_thr) begin
            w_state_next = RELEASE;
            w_gain_next  = w_ramp_dn;
          end else begin
            w_gain_next = w_ramp_up;
            if (w_ramp_up == GAIN_FULL) w_state_next = OPEN;
          end
        end
        OPEN: begin
          w_gain_next = GAIN_FULL;
          if (w_abs < w_close_thr) begin
            w_state_next = HOLD;
            w_hold_next  = HOLD_W'(HOLD_SAMPLES - 1);
          end
        end
        HOLD: begin
          w_gain_next = GAIN_FULL;
          if (w_abs >= w_open_thr) begin
            w_state_next = OPEN;
          end else if (r_hold == '0) begin
            w_state_next = RELEASE;
            w_gain_next  = sat_sub(GAIN_FULL, REL_W);
          end else begin
            w_hold_next = r_hold - 1'b1;
          end
        end
        RELEASE: begin
          if (w_abs >= w_open_thr) begin
            w_gain_next  = w_ramp_up;
            w_state_next = (w_ramp_up == GAIN_FULL) ? OPEN : ATTACK;
          end else begin
            w_gain_next = w_ramp_dn;
            if (w_ramp_dn == 32'd0) w_state_next = CLOSED;
          end
        end
        default: begin
          w_state_next = CLOSED;
          w_gain_next  = 32'd0;
        end
      endcase
    end
  end

  gate_gain_apply #(
    .DATA_W(DATA_W),
    .GAIN_W(GAIN_W)
  ) u_gain_apply (
    .i_sample(i_data),
    .i_gain  ((GAIN_W+1)'(w_gain_next)),
    .o_sample(w_scaled)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= CLOSED;
      r_gain  <= '0;
      r_hold  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data  <= i_enable ? w_scaled : i_data;
        r_state <= w_state_next;
        r_gain  <= (GAIN_W+1)'(w_gain_next);
        r_hold  <= w_hold_next;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

`ifdef EFFECT_GATE_METER_EN
  logic [2:0]      r_meter_state;
  logic [GAIN_W:0] r_meter_gain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meter_state <= 3'(CLOSED);
      r_meter_gain  <= '0;
    end else if (i_valid) begin
      r_meter_state <= 3'(w_state_next);
      r_meter_gain  <= (GAIN_W+1)'(w_gain_next);
    end
  end

  assign o_state = r_meter_state;
  assign o_gain  = r_meter_gain;
`else
  // Default build carries no meter registers; audio path is unchanged.
`endif

endmodule

// File: tb/tb_effect_gate_env.sv
// Directed bench for effect_gate_env at default parameters, expected values hand-computed.
module tb_effect_gate_env;

  logic               i_clk    = 1'b0;
  logic               i_rst    = 1'b1;
  logic               i_valid  = 1'b0;
  logic               i_enable = 1'b1;
  logic        [2:0]  i_level  = 3'd4;
  logic signed [15:0] i_data   = '0;
  logic signed [15:0] o_data;
  logic               o_valid;
`ifdef EFFECT_GATE_METER_EN
  logic        [2:0]  o_state;
  logic        [8:0]  o_gain;
`endif

  int n_checks = 0;
  int n_errors = 0;

  effect_gate_env dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_enable(i_enable),
    .i_level (i_level),
    .i_data  (i_data),
    .o_data  (o_data),
    .o_valid (o_valid)
`ifdef EFFECT_GATE_METER_EN
    ,
    .o_state (o_state),
    .o_gain  (o_gain)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One valid sample per cycle; result sampled 1 ns after the capturing edge.
  task automatic sample(input int d, input int exp, input string tag);
    i_data  = 16'(d);
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    check(tag, int'(o_data), exp);
    check({tag, "_vld"}, int'(o_valid), 1);
    i_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  int atk_exp[4] = '{50, 100, 150, 200};
  int rel_exp[6] = '{80, 80, 80, 80, 70, 60};

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_data", int'(o_data), 0);
    check("rst_valid", int'(o_valid), 0);
`ifdef EFFECT_GATE_METER_EN
    check("rst_state", int'(o_state), 0);
`endif
    i_rst = 1'b0;

    // Attack ramp at level 4 (open 100, close 90)
    sample(50, 0, "below_open");
    foreach (atk_exp[k]) sample(200, atk_exp[k], $sformatf("attack%0d", k));
`ifdef EFFECT_GATE_METER_EN
    check("state_open", int'(o_state), 2);
`endif

    // Hysteresis band holds OPEN, then hold timer and release ramp
    sample(95, 95, "band_open");
    foreach (rel_exp[k]) sample(80, rel_exp[k], $sformatf("hold_rel%0d", k));

    // Retrigger from RELEASE at gain 192 saturates straight to unity
    sample(300, 300, "retrigger");
    sample(95, 95, "open_after_retrig");

    // Asynchronous reset mid-stream: outputs clear before any clock edge
    i_rst = 1'b1;
    #1;
    check("async_rst_data", int'(o_data), 0);
    check("async_rst_valid", int'(o_valid), 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Level 0 opens on any input; negative product floors
    i_level = 3'd0;
    sample(-1, -1, "floor_neg");

    // Most-negative input saturates its magnitude and opens at level 7
    pulse_reset();
    i_level = 3'd7;
    sample(-32768, -8192, "sat_min");

    // Bypass: unchanged data, 1-cycle valid, data held between strobes
    i_enable = 1'b0;
    sample(5, 5, "byp_pos");
    sample(0, 0, "byp_zero");
    sample(-3, -3, "byp_neg");
    @(posedge i_clk);
    #1;
    check("idle_valid", int'(o_valid), 0);
    check("idle_hold", int'(o_data), -3);
    @(posedge i_clk);
    #1;
    check("idle_hold2", int'(o_data), -3);

    // Re-enable resumes OPEN, so a band-level sample passes at unity
    i_enable = 1'b1;
    i_level  = 3'd4;
    sample(95, 95, "reenable_band");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
